// File: rtl/cell_plotter.sv
// cell_plotter: buffers cell-change events in a small FIFO and expands each
// one into a CELL_SIZE x CELL_SIZE block of pixel writes for the 160x120 VGA
// adapter (one pixel per clock), plus a full-screen clear-to-black sweep.
// Optional build macro CELL_PLOTTER_GRID_EN: the top row and left column of
// every drawn cell are painted blue (3'b001) to form a grid.
module cell_plotter #(
    parameter int CELL_SIZE  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_cell_x,
    input  logic [7:0] in_cell_y,
    input  logic [2:0] in_colour,
    input  logic       clear_req,
    output logic [7:0] out_x,
    output logic [7:0] out_y,
    output logic [2:0] out_colour,
    output logic       plot,
    output logic       busy
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CSH = $clog2(CELL_SIZE);

    localparam logic [7:0]  CELL_LAST = 8'(CELL_SIZE - 1);
    localparam logic [7:0]  X_LAST    = 8'(SCREEN_W - 1);
    localparam logic [7:0]  Y_LAST    = 8'(SCREEN_H - 1);
    localparam logic [10:0] W_LIM     = 11'(SCREEN_W);
    localparam logic [10:0] H_LIM     = 11'(SCREEN_H);

    typedef struct packed {
        logic [7:0] cell_x;
        logic [7:0] cell_y;
        logic [2:0] colour;
    } cell_evt_t;

    typedef enum logic [1:0] {IDLE, DRAW, CLEAR} state_t;

    state_t     state, state_nxt;
    cell_evt_t  mem [FIFO_DEPTH];
    cell_evt_t  rd_evt;
    logic [AW:0] wr_ptr, rd_ptr;
    logic       full, empty, push, pop;
    logic       clear_pending;

    // Cell origin in pixels; 11 bits holds 255*8 so nothing is truncated.
    logic [10:0] base_x, base_y;
    logic [10:0] px, py;
    logic [2:0]  colour_q, pix_colour;
    logic [7:0]  cnt_x, cnt_y;
    logic        draw_last, clear_last;

    logic [7:0] out_x_nxt, out_y_nxt;
    logic [2:0] out_colour_nxt;
    logic       plot_nxt;

    // FIFO bookkeeping; the extra pointer bit separates full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state == IDLE) && !clear_pending && !empty;
    assign rd_evt   = mem[rd_ptr[AW-1:0]];
    assign busy     = !empty || (state != IDLE) || clear_pending;

    assign px         = base_x + {3'b000, cnt_x};
    assign py         = base_y + {3'b000, cnt_y};
    assign draw_last  = (cnt_x == CELL_LAST) && (cnt_y == CELL_LAST);
    assign clear_last = (cnt_x == X_LAST) && (cnt_y == Y_LAST);

`ifdef CELL_PLOTTER_GRID_EN
    assign pix_colour = ((CELL_SIZE >= 2) && (cnt_x == 8'd0 || cnt_y == 8'd0)) ? 3'b001 : colour_q;
`else
    assign pix_colour = colour_q;
`endif

    // FIFO storage: written on accepted pushes only, no reset needed.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= '{cell_x: in_cell_x, cell_y: in_cell_y, colour: in_colour};
    end

    // FIFO pointers and the clear request latch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            clear_pending <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // IDLE consumes a pending clear; a new request always re-arms it.
            clear_pending <= (clear_pending && (state != IDLE)) || clear_req;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic: a pending clear outranks queued cells.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_pending) state_nxt = CLEAR;
                     else if (!empty)   state_nxt = DRAW;
            DRAW:    if (draw_last)     state_nxt = IDLE;
            CLEAR:   if (clear_last)    state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Pixel counters and per-cell latches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_x    <= '0;
            cnt_y    <= '0;
            base_x   <= '0;
            base_y   <= '0;
            colour_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_x <= '0;
                    cnt_y <= '0;
                    if (pop) begin
                        base_x   <= {3'b000, rd_evt.cell_x} << CSH;
                        base_y   <= {3'b000, rd_evt.cell_y} << CSH;
                        colour_q <= rd_evt.colour;
                    end
                end
                DRAW: begin
                    if (cnt_x == CELL_LAST) begin
                        cnt_x <= '0;
                        cnt_y <= cnt_y + 8'd1;
                    end else begin
                        cnt_x <= cnt_x + 8'd1;
                    end
                end
                CLEAR: begin
                    if (cnt_x == X_LAST) begin
                        cnt_x <= '0;
                        cnt_y <= cnt_y + 8'd1;
                    end else begin
                        cnt_x <= cnt_x + 8'd1;
                    end
                end
                default: begin
                    cnt_x <= '0;
                    cnt_y <= '0;
                end
            endcase
        end
    end

    // Output decode: off-screen cell pixels are skipped but still take a cycle.
    always_comb begin
        out_x_nxt      = out_x;
        out_y_nxt      = out_y;
        out_colour_nxt = out_colour;
        plot_nxt       = 1'b0;
        case (state)
            DRAW: begin
                if (px < W_LIM && py < H_LIM) begin
                    out_x_nxt      = px[7:0];
                    out_y_nxt      = py[7:0];
                    out_colour_nxt = pix_colour;
                    plot_nxt       = 1'b1;
                end
            end
            CLEAR: begin
                out_x_nxt      = cnt_x;
                out_y_nxt      = cnt_y;
                out_colour_nxt = 3'b000;
                plot_nxt       = 1'b1;
            end
            default: plot_nxt = 1'b0;
        endcase
    end

    // Registered adapter outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_x      <= '0;
            out_y      <= '0;
            out_colour <= '0;
            plot       <= 1'b0;
        end else begin
            out_x      <= out_x_nxt;
            out_y      <= out_y_nxt;
            out_colour <= out_colour_nxt;
            plot       <= plot_nxt;
        end
    end

    // The last clear pixel lands just before Y_LAST wraps; keep Y_LAST used.
    logic unused_ok;
    assign unused_ok = &{1'b0, Y_LAST};

endmodule
